// File: rtl/perf_counter_bank_if.sv
// perf_counter_bank_if: MEM-stage access bus (address/read/write/wdata from the CPU; select, pass-through, read data and response from the bank)
interface perf_counter_bank_if;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic        ctr_sel;
  logic        pass_read;
  logic        pass_write;
  logic [31:0] ctr_rdata;
  logic        ctr_resp;
  modport master (
    output mem_address, mem_read, mem_write, mem_wdata,
    input  ctr_sel, pass_read, pass_write, ctr_rdata, ctr_resp
  );
  modport slave (
    input  mem_address, mem_read, mem_write, mem_wdata,
    output ctr_sel, pass_read, pass_write, ctr_rdata, ctr_resp
  );
endinterface

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: memory-mapped perf counters (clk, rst, event_inc strobes, bus slave port); define PERF_SATURATE_EN for saturating counters
module perf_counter_bank #(
  parameter int          NUM_COUNTERS = 8,
  parameter int          CNT_WIDTH    = 32,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_COUNTERS-1:0] event_inc,
  perf_counter_bank_if.slave      bus
);
`ifdef PERF_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam int N = NUM_COUNTERS;
  logic [CNT_WIDTH-1:0] cnt [N];
  logic [N-1:0]         ovf, ovf_set;
  logic                 freeze, resp;
  logic [31:0]          diff, rword, rdata;
  logic [29:0]          k;
  logic                 unused_lsb;
  logic                 wr, acc, ctrl_wr, ovf_wr, clear;
  assign diff            = bus.mem_address - BASE_ADDR;
  assign k               = diff[31:2];
  assign unused_lsb      = ^diff[1:0];
  assign bus.ctr_sel     = diff < 32'(4 * (N + 2));
  assign bus.pass_read   = bus.mem_read & ~bus.ctr_sel;
  assign bus.pass_write  = bus.mem_write & ~bus.ctr_sel;
  assign bus.ctr_rdata   = rdata;
  assign bus.ctr_resp    = resp;
  assign wr      = bus.ctr_sel & bus.mem_write;
  assign acc     = bus.ctr_sel & (bus.mem_read | bus.mem_write);
  assign ctrl_wr = wr && k == 30'(N);
  assign ovf_wr  = wr && k == 30'(N + 1);
  assign clear   = ctrl_wr & bus.mem_wdata[1];
  always_comb begin
    rword = '0;
    for (int i = 0; i < N; i++) rword = k == 30'(i) ? 32'(cnt[i]) : rword;
    rword = k == 30'(N) ? {31'b0, freeze} : rword;
    rword = k == 30'(N + 1) ? 32'(ovf) : rword;
  end
  // an overflow only counts when the increment actually lands (not dropped by a CPU write)
  always_comb begin
    ovf_set = '0;
    for (int i = 0; i < N; i++)
      ovf_set[i] = event_inc[i] & ~freeze & (&cnt[i]) & ~(wr && k == 30'(i));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) cnt[i] <= '0;
      ovf    <= '0;
      freeze <= 1'b0;
      resp   <= 1'b0;
      rdata  <= '0;
    end else begin
      resp   <= acc;
      rdata  <= acc ? rword : rdata;
      freeze <= ctrl_wr ? bus.mem_wdata[0] : freeze;
      for (int i = 0; i < N; i++)
        cnt[i] <= clear ? '0 :
                  (wr && k == 30'(i)) ? bus.mem_wdata[CNT_WIDTH-1:0] :
                  (event_inc[i] && !freeze) ? ((SAT && (&cnt[i])) ? cnt[i] : cnt[i] + CNT_WIDTH'(1)) :
                  cnt[i];
      ovf <= clear ? '0 : (ovf & ~(ovf_wr ? bus.mem_wdata[N-1:0] : '0)) | ovf_set;
    end
  end
endmodule

// File: tb/tb_perf_counter_bank.sv
// tb_perf_counter_bank: directed checks of an 8x32 bank at base 0 and a 4x4 bank at base 0x100
module tb_perf_counter_bank;
`ifdef PERF_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] event_inc_a = '0;
  logic [3:0] event_inc_b = '0;
  int checks = 0;
  int errors = 0;
  bit s, p_r, p_w, rsp;
  logic [31:0] rv;
  perf_counter_bank_if ia ();
  perf_counter_bank_if ib ();
  perf_counter_bank #(.NUM_COUNTERS(8), .CNT_WIDTH(32), .BASE_ADDR(32'h0)) ua (
    .clk(clk), .rst(rst), .event_inc(event_inc_a), .bus(ia.slave));
  perf_counter_bank #(.NUM_COUNTERS(4), .CNT_WIDTH(4), .BASE_ADDR(32'h100)) ub (
    .clk(clk), .rst(rst), .event_inc(event_inc_b), .bus(ib.slave));
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // called at a negedge; drives one access for one cycle, returns comb and registered observations
  task automatic access(input bit b, input logic [31:0] addr, input bit r, input bit w, input logic [31:0] d,
                        output bit sel, output bit pr, output bit pw, output bit resp, output logic [31:0] rd);
    if (b) begin
      ib.mem_address = addr; ib.mem_read = r; ib.mem_write = w; ib.mem_wdata = d;
    end else begin
      ia.mem_address = addr; ia.mem_read = r; ia.mem_write = w; ia.mem_wdata = d;
    end
    #1;
    sel = b ? ib.ctr_sel : ia.ctr_sel;
    pr  = b ? ib.pass_read : ia.pass_read;
    pw  = b ? ib.pass_write : ia.pass_write;
    @(negedge clk);
    resp = b ? ib.ctr_resp : ia.ctr_resp;
    rd   = b ? ib.ctr_rdata : ia.ctr_rdata;
    ia.mem_read = 1'b0; ia.mem_write = 1'b0;
    ib.mem_read = 1'b0; ib.mem_write = 1'b0;
  endtask

  task automatic test_reset;
    ia.mem_address = '0; ia.mem_read = 1'b0; ia.mem_write = 1'b0; ia.mem_wdata = '0;
    ib.mem_address = '0; ib.mem_read = 1'b0; ib.mem_write = 1'b0; ib.mem_wdata = '0;
    rst = 1'b1;
    cyc(3);
    checks++; if (ia.ctr_resp !== 1'b0) begin errors++; $display("FAIL reset_resp: got %b expected 0", ia.ctr_resp); end
    checks++; if (ia.ctr_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", ia.ctr_rdata); end
    rst = 1'b0;
    for (int o = 0; o < 10; o++) begin
      access(0, 32'(o * 4), 1, 0, 0, s, p_r, p_w, rsp, rv);
      checks++; if (s !== 1'b1) begin errors++; $display("FAIL reset_sel[%0d]: got %b expected 1", o, s); end
      checks++; if (p_r !== 1'b0) begin errors++; $display("FAIL reset_pass_read[%0d]: got %b expected 0", o, p_r); end
      checks++; if (rsp !== 1'b1) begin errors++; $display("FAIL reset_read_resp[%0d]: got %b expected 1", o, rsp); end
      checks++; if (rv !== 32'h0) begin errors++; $display("FAIL reset_read[%0d]: got %h expected 0", o, rv); end
    end
  endtask

  task automatic test_count;
    event_inc_a = 8'h08; cyc(5); event_inc_a = '0;
    access(0, 32'h0C, 1, 0, 0, s, p_r, p_w, rsp, rv);
    checks++; if (rv !== 32'd5) begin errors++; $display("FAIL count_c3: got %h expected 5", rv); end
    access(0, 32'h40, 1, 0, 0, s, p_r, p_w, rsp, rv);
    checks++; if (s !== 1'b0) begin errors++; $display("FAIL outside_sel: got %b expected 0", s); end
    checks++; if (p_r !== 1'b1) begin errors++; $display("FAIL outside_pass_read: got %b expected 1", p_r); end
    checks++; if (rsp !== 1'b0) begin errors++; $display("FAIL outside_resp: got %b expected 0", rsp); end
    access(0, 32'h44, 0, 1, 32'hDEAD, s, p_r, p_w, rsp, rv);
    checks++; if (p_w !== 1'b1) begin errors++; $display("FAIL outside_pass_write: got %b expected 1", p_w); end
    access(0, 32'h28, 1, 0, 0, s, p_r, p_w, rsp, rv);
    checks++; if (s !== 1'b0) begin errors++; $display("FAIL edge_above_sel: got %b expected 0", s); end
    access(0, 32'h27, 1, 0, 0, s, p_r, p_w, rsp, rv);
    checks++; if (s !== 1'b1 || rsp !== 1'b1) begin errors++; $display("FAIL edge_last_word: got sel %b resp %b expected 1 1", s, rsp); end
    checks++; if (rv !== 32'h0) begin errors++; $display("FAIL edge_last_ovf: got %h expected 0", rv); end
    access(0, 32'h14, 0, 1, 32'hFFFF_FFFF, s, p_r, p_w, rsp, rv);
    checks++; if (rsp !== 1'b1 || rv !== 32'h0) begin errors++; $display("FAIL preload_c5: got resp %b old %h expected 1 0", rsp, rv); end
    event_inc_a = 8'h20; cyc(1); event_inc_a = '0;
    access(0, 32'h14, 1, 0, 0, s, p_r, p_w, rsp, rv);
    checks++; if (rv !== (SAT ? 32'hFFFF_FFFF : 32'h0)) begin errors++; $display("FAIL wrap_c5: got %h expected %h", rv, SAT ? 32'hFFFF_FFFF : 32'h0); end
    access(0, 32'h24, 1, 0, 0, s, p_r, p_w, rsp, rv);
    checks++; if (rv !== 32'h20) begin errors++; $display("FAIL wrap_ovf: got %h expected 20", rv); end
  endtask

  task automatic test_freeze;
    event_inc_a = 8'hFF;
    access(0, 32'h20, 0, 1, 32'h1, s, p_r, p_w, rsp, rv);
    cyc(10);
    event_inc_a = '0;
    access(0, 32'h00, 1, 0, 0, s, p_r, p_w, rsp, rv);
    checks++; if (rv !== 32'd1) begin errors++; $display("FAIL freeze_c0: got %h expected 1", rv); end
    access(0, 32'h0C, 1, 0, 0, s, p_r, p_w, rsp, rv);
    checks++; if (rv !== 32'd6) begin errors++; $display("FAIL freeze_c3: got %h expected 6", rv); end
    access(0, 32'h20, 1, 0, 0, s, p_r, p_w, rsp, rv);
    checks++; if (rv !== 32'd1) begin errors++; $display("FAIL freeze_ctrl: got %h expected 1", rv); end
    access(0, 32'h20, 0, 1, 32'h2, s, p_r, p_w, rsp, rv);
    checks++; if (rv !== 32'd1) begin errors++; $display("FAIL clear_old_ctrl: got %h expected 1", rv); end
    access(0, 32'h00, 1, 0, 0, s, p_r, p_w, rsp, rv);
    checks++; if (rv !== 32'd0) begin errors++; $display("FAIL clear_c0: got %h expected 0", rv); end
    access(0, 32'h0C, 1, 0, 0, s, p_r, p_w, rsp, rv);
    checks++; if (rv !== 32'd0) begin errors++; $display("FAIL clear_c3: got %h expected 0", rv); end
    access(0, 32'h14, 1, 0, 0, s, p_r, p_w, rsp, rv);
    checks++; if (rv !== 32'd0) begin errors++; $display("FAIL clear_c5: got %h expected 0", rv); end
    access(0, 32'h20, 1, 0, 0, s, p_r, p_w, rsp, rv);
    checks++; if (rv !== 32'd0) begin errors++; $display("FAIL clear_ctrl: got %h expected 0", rv); end
    access(0, 32'h24, 1, 0, 0, s, p_r, p_w, rsp, rv);
    checks++; if (rv !== 32'd0) begin errors++; $display("FAIL clear_ovf: got %h expected 0", rv); end
    event_inc_a = 8'h01; cyc(1); event_inc_a = '0;
    access(0, 32'h00, 1, 0, 0, s, p_r, p_w, rsp, rv);
    checks++; if (rv !== 32'd1) begin errors++; $display("FAIL unfreeze_c0: got %h expected 1", rv); end
  endtask

  task automatic test_collision;
    event_inc_a = 8'h02;
    access(0, 32'h04, 0, 1, 32'h100, s, p_r, p_w, rsp, rv);
    event_inc_a = '0;
    access(0, 32'h04, 1, 0, 0, s, p_r, p_w, rsp, rv);
    checks++; if (rv !== 32'h100) begin errors++; $display("FAIL write_vs_inc_c1: got %h expected 100", rv); end
    event_inc_a = 8'hFF;
    access(0, 32'h20, 0, 1, 32'h2, s, p_r, p_w, rsp, rv);
    event_inc_a = '0;
    for (int i = 0; i < 8; i++) begin
      access(0, 32'(i * 4), 1, 0, 0, s, p_r, p_w, rsp, rv);
      checks++; if (rv !== 32'h0) begin errors++; $display("FAIL clear_vs_inc_c%0d: got %h expected 0", i, rv); end
    end
  endtask

  task automatic test_back_to_back;
    event_inc_a = 8'h01; cyc(2); event_inc_a = '0;
    access(0, 32'h08, 0, 1, 32'd7, s, p_r, p_w, rsp, rv);
    access(0, 32'h00, 1, 0, 0, s, p_r, p_w, rsp, rv);
    checks++; if (rsp !== 1'b1 || rv !== 32'd2) begin errors++; $display("FAIL b2b_c0: got resp %b data %h expected 1 2", rsp, rv); end
    access(0, 32'h04, 1, 0, 0, s, p_r, p_w, rsp, rv);
    checks++; if (rsp !== 1'b1 || rv !== 32'd0) begin errors++; $display("FAIL b2b_c1: got resp %b data %h expected 1 0", rsp, rv); end
    access(0, 32'h08, 1, 1, 32'd9, s, p_r, p_w, rsp, rv);
    checks++; if (rsp !== 1'b1 || rv !== 32'd7) begin errors++; $display("FAIL b2b_rw_old: got resp %b data %h expected 1 7", rsp, rv); end
    access(0, 32'h08, 1, 0, 0, s, p_r, p_w, rsp, rv);
    checks++; if (rv !== 32'd9) begin errors++; $display("FAIL b2b_rw_new: got %h expected 9", rv); end
    cyc(1);
    checks++; if (ia.ctr_resp !== 1'b0) begin errors++; $display("FAIL idle_resp: got %b expected 0", ia.ctr_resp); end
    checks++; if (ia.ctr_rdata !== 32'd9) begin errors++; $display("FAIL idle_hold: got %h expected 9", ia.ctr_rdata); end
  endtask

  task automatic test_narrow;
    access(1, 32'h108, 0, 1, 32'hF, s, p_r, p_w, rsp, rv);
    checks++; if (rsp !== 1'b1 || rv !== 32'h0) begin errors++; $display("FAIL n_preload: got resp %b old %h expected 1 0", rsp, rv); end
    event_inc_b = 4'h4; cyc(1); event_inc_b = '0;
    access(1, 32'h108, 1, 0, 0, s, p_r, p_w, rsp, rv);
    checks++; if (rv !== (SAT ? 32'hF : 32'h0)) begin errors++; $display("FAIL n_wrap_c2: got %h expected %h", rv, SAT ? 32'hF : 32'h0); end
    access(1, 32'h114, 1, 0, 0, s, p_r, p_w, rsp, rv);
    checks++; if (rv !== 32'h4) begin errors++; $display("FAIL n_ovf_set: got %h expected 4", rv); end
    access(1, 32'h114, 0, 1, 32'h4, s, p_r, p_w, rsp, rv);
    checks++; if (rv !== 32'h4) begin errors++; $display("FAIL n_ovf_w1c_old: got %h expected 4", rv); end
    access(1, 32'h114, 1, 0, 0, s, p_r, p_w, rsp, rv);
    checks++; if (rv !== 32'h0) begin errors++; $display("FAIL n_ovf_w1c: got %h expected 0", rv); end
    access(1, 32'hFC, 1, 0, 0, s, p_r, p_w, rsp, rv);
    checks++; if (s !== 1'b0 || rsp !== 1'b0) begin errors++; $display("FAIL n_below: got sel %b resp %b expected 0 0", s, rsp); end
    access(1, 32'h118, 1, 0, 0, s, p_r, p_w, rsp, rv);
    checks++; if (s !== 1'b0) begin errors++; $display("FAIL n_above: got %b expected 0", s); end
    access(1, 32'h104, 0, 1, 32'h1234, s, p_r, p_w, rsp, rv);
    access(1, 32'h107, 1, 0, 0, s, p_r, p_w, rsp, rv);
    checks++; if (s !== 1'b1 || rv !== 32'h4) begin errors++; $display("FAIL n_trunc_c1: got sel %b data %h expected 1 4", s, rv); end
  endtask

  task automatic test_reset_mid;
    ia.mem_address = 32'h08; ia.mem_read = 1'b1;
    @(negedge clk);
    ia.mem_read = 1'b0;
    checks++; if (ia.ctr_resp !== 1'b1) begin errors++; $display("FAIL mid_pre_resp: got %b expected 1", ia.ctr_resp); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (ia.ctr_resp !== 1'b0) begin errors++; $display("FAIL mid_resp: got %b expected 0", ia.ctr_resp); end
    checks++; if (ia.ctr_rdata !== 32'h0) begin errors++; $display("FAIL mid_rdata: got %h expected 0", ia.ctr_rdata); end
    rst = 1'b0;
    access(0, 32'h08, 1, 0, 0, s, p_r, p_w, rsp, rv);
    checks++; if (rv !== 32'h0) begin errors++; $display("FAIL mid_c2: got %h expected 0", rv); end
    access(0, 32'h00, 1, 0, 0, s, p_r, p_w, rsp, rv);
    checks++; if (rv !== 32'h0) begin errors++; $display("FAIL mid_c0: got %h expected 0", rv); end
  endtask

  initial begin
    test_reset;
    test_count;
    test_freeze;
    test_collision;
    test_back_to_back;
    test_narrow;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule

// File: doc/perf_counter_bank.md
# perf_counter_bank

Parametrised, memory-mapped bank of hardware performance counters that sits beside the MEM stage. It decodes a configurable address window, owns the counters and increments them from per-event strobes. It serves loads and stores to the window with a registered one-cycle response, and forwards all other accesses to the data-memory path. Over a fixed 8-counter combinational mux it adds freeze, clear-all, per-counter preload, sticky overflow status and a parametrised count and width.

## Interface
- NUM_COUNTERS, 8: number of counters, 1..30
- CNT_WIDTH, 32: counter width in bits, 1..32; reads are zero-extended to 32 bits
- BASE_ADDR, 32'h0000_0000: byte base of the window; must be 4-byte aligned
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- event_inc  in  NUM_COUNTERS  bit i pulses to increment counter i by 1 this cycle
- mem_address  in  32  byte address from EX/MEM
- mem_read  in  1  load request
- mem_write  in  1  store request; full-word only, byte enables ignored in the window
- mem_wdata  in  32  store data
- ctr_sel  out  1  combinational; 1 when mem_address is in the window
- pass_read  out  1  combinational; mem_read & ~ctr_sel
- pass_write  out  1  combinational; mem_write & ~ctr_sel
- ctr_rdata  out  32  registered read data
- ctr_resp  out  1  registered; one-cycle pulse completing an in-window access

## Operation
- Window covers BASE_ADDR through BASE_ADDR + 4*(NUM_COUNTERS+2) - 1. Word offset k = (mem_address - BASE_ADDR) >> 2; address bits [1:0] are ignored.
- Offsets 0..N-1: counter k. Read returns its value. Write loads mem_wdata[CNT_WIDTH-1:0].
- Offset N: CTRL register.
  - Bit0 FREEZE is read/write.
  - Bit1 CLEAR is write-only and self-clearing; writing 1 zeroes all counters and OVF. It reads as 0.
  - Other bits read as 0.
- Offset N+1: OVF register, read-only status.
  - Bit i is set when counter i wraps (or saturates, see Configuration).
  - A write clears each bit where mem_wdata has a 1 (W1C).
  - Bits at or above N read as 0.
- Increment: if FREEZE=0 and event_inc[i]=1, counter i += 1, modulo 2^CNT_WIDTH.
- Per-edge priority for counter i:
  1. rst
  2. CLEAR
  3. write to counter i
  4. increment
- A write to counter i in the same cycle as event_inc[i] drops that increment.
- A write to CTRL setting FREEZE takes effect for increments from the next cycle; same-cycle strobes still count.
- OVF set and W1C clear of the same bit in the same cycle: set wins.
- An access with mem_read and mem_write both high is a write. ctr_rdata returns the pre-write value of the addressed word.
- Accesses outside the window produce no ctr_resp, and no counter or register changes.

## Timing
- Reset: all counters 0, FREEZE 0, OVF 0, ctr_rdata 0, ctr_resp 0.
- Read accepted at edge T (ctr_sel & mem_read):
  - ctr_rdata holds the word's value from before edge T; increments at T are not visible.
  - ctr_resp=1 in cycle T+1 and returns to 0 in T+2 unless a new access is accepted.
- Write accepted at edge T: the register updates at T. ctr_resp=1 in cycle T+1. ctr_rdata holds the old value.
- Back-to-back accesses are allowed every cycle. Each produces its own one-cycle-late ctr_resp, so ctr_resp can stay high.
- ctr_rdata holds its last value while ctr_resp=0.
- rst asserted mid-access clears the pending ctr_resp at the same edge.
- Wrap: counter at 2^CNT_WIDTH-1 with an increment becomes 0 and sets OVF[i] at the same edge.

## Configuration
- PERF_SATURATE_EN defined: a counter at 2^CNT_WIDTH-1 holds that value on increment and sets OVF[i]. A CPU write can still load any value.
- PERF_SATURATE_EN undefined: counters wrap to 0 and set OVF[i].

## Test plan
- Reset, then read offsets 0..N+1 at BASE_ADDR=0 (N=8): every read returns 0 with ctr_resp one cycle after each request; pass_read stays 0.
- Pulse event_inc[3] for 5 cycles, then read address 0x0C: ctr_rdata=5. A read at address 0x40 gives pass_read=1, ctr_sel=0, and no ctr_resp.
- CNT_WIDTH=4: preload counter 2 with 0xF by write, then pulse event_inc[2] once.
  - Wrap build: counter 2 reads 0, OVF reads 0x4.
  - PERF_SATURATE_EN build: counter 2 reads 0xF, OVF reads 0x4.
  - Then write 0x4 to OVF: OVF reads 0.
- Write CTRL=1 (FREEZE), pulse all event_inc for 10 cycles, then read counter 0: value unchanged plus at most the strobe of the write cycle. Write CTRL=2: all counters and OVF read 0, FREEZE reads 0.
- Same-cycle write of 0x100 to counter 1 with event_inc[1]=1: counter 1 reads 0x100. Same-cycle CLEAR with event_inc=all ones: all counters read 0.
- Assert rst the cycle after an in-window read: ctr_resp=0, ctr_rdata=0 after that edge, all counters 0.
